// File: rtl/div_unit.sv
// 32-bit restoring radix-2 divider, signed/unsigned, one quotient bit per clock.
// Divide-by-zero completes on the accepting edge with all-ones quotient and remainder = dividend.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    input  logic        div_signed,
    input  logic        cancel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        div_ready,
    output logic        done,
    output logic [31:0] Quotient,
    output logic [31:0] Remainder,
    output logic        DivZero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;        // partial remainder
    logic [31:0] dvd_q, dvd_d;        // dividend shifts out the top, quotient bits shift in the bottom
    logic [31:0] dvs_q, dvs_d;        // divisor magnitude
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rmd_q, rmd_d;
    logic        dz_q, dz_d;

    // Operand magnitudes and signs at accept time
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        accept;

    // One restoring step
    logic [33:0] shifted;
    logic [33:0] trial;
    logic [32:0] rem_step;
    logic [31:0] q_step;
    logic [31:0] q_fix, r_fix;

    always_comb begin
        a_neg  = div_signed & A[31];
        b_neg  = div_signed & B[31];
        a_mag  = a_neg ? (32'd0 - A) : A;
        b_mag  = b_neg ? (32'd0 - B) : B;
        accept = (state_q == IDLE) && div_valid && !cancel;
    end

    always_comb begin
        shifted = {rem_q, dvd_q[31]};
        trial   = shifted - {2'b00, dvs_q};
        if (trial[33]) begin
            rem_step = shifted[32:0];
            q_step   = {dvd_q[30:0], 1'b0};
        end else begin
            rem_step = trial[32:0];
            q_step   = {dvd_q[30:0], 1'b1};
        end
        // Remainder magnitude is always below |B|, so its low 32 bits carry the full value
        q_fix = q_neg_q ? (32'd0 - q_step) : q_step;
        r_fix = r_neg_q ? (32'd0 - rem_step[31:0]) : rem_step[31:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (B == 32'd0) begin
                        quo_d   = 32'hFFFF_FFFF;
                        rmd_d   = A;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        rem_d   = 33'd0;
                        dvd_d   = a_mag;
                        dvs_d   = b_mag;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        cnt_d   = 5'd31;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_step;
                    dvd_d = q_step;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        quo_d   = q_fix;
                        rmd_d   = r_fix;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 33'd0;
            dvd_q   <= 32'd0;
            dvs_q   <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            quo_q   <= 32'd0;
            rmd_q   <= 32'd0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
        end
    end

    assign div_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign Quotient  = quo_q;
    assign Remainder = rmd_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results/latency, hand sequences for cancel and reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_signed;
    logic        cancel;
    logic [31:0] A, B;
    logic        div_ready, done;
    logic [31:0] Quotient, Remainder;
    logic        DivZero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .div_valid (div_valid),
        .div_signed(div_signed),
        .cancel    (cancel),
        .A         (A),
        .B         (B),
        .div_ready (div_ready),
        .done      (done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .DivZero   (DivZero)
    );

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        bit          exp_dz;
        int          exp_lat;   // clock edges after the accepting edge until done is seen
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one operation and wait (bounded) for done; lat = 999 on timeout.
    task automatic run_op(input bit sg, input logic [31:0] a, input logic [31:0] b, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!div_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        div_signed = sg;
        A          = a;
        B          = b;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) lat = 999;
    endtask

    initial begin
        int lat;
        int done_seen;
        logic [31:0] pq, pr;
        logic        pdz;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 32};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 32};
        vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0, 32};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 32};
        vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 32};
        vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 0};
        vecs[6]  = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0, 32};
        vecs[7]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 32};
        vecs[8]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 32};
        vecs[9]  = '{1'b1, 32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1, 0};
        vecs[10] = '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 32};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0, 32};

        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        cancel     = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        check("reset_q",     Quotient,  32'd0);
        check("reset_r",     Remainder, 32'd0);
        check("reset_dz",    {31'd0, DivZero},   32'd0);
        check("reset_done",  {31'd0, done},      32'd0);
        check("reset_ready", {31'd0, div_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
            $display("op %0d: %s %h / %h -> q=%h r=%h dz=%0d lat=%0d",
                     i, vecs[i].sgn ? "s" : "u", vecs[i].a, vecs[i].b,
                     Quotient, Remainder, DivZero, lat);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_q", i),   Quotient,  vecs[i].exp_q);
            check($sformatf("v%0d_r", i),   Remainder, vecs[i].exp_r);
            check($sformatf("v%0d_dz", i),  {31'd0, DivZero}, {31'd0, vecs[i].exp_dz});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), {31'd0, done},      32'd0);
            check($sformatf("v%0d_ready", i),      {31'd0, div_ready}, 32'd1);
            check($sformatf("v%0d_hold_q", i),     Quotient,  vecs[i].exp_q);
        end

        // Cancel in the 10th BUSY cycle: outputs keep the previous result, no done follows
        pq  = vecs[NV-1].exp_q;
        pr  = vecs[NV-1].exp_r;
        pdz = vecs[NV-1].exp_dz;
        @(negedge clk);
        div_signed = 1'b0;
        A          = 32'd100;
        B          = 32'd7;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_ready", {31'd0, div_ready}, 32'd1);
        check("cancel_done",  {31'd0, done},      32'd0);
        check("cancel_q",     Quotient,  pq);
        check("cancel_r",     Remainder, pr);
        check("cancel_dz",    {31'd0, DivZero}, {31'd0, pdz});
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("cancel_no_done", done_seen, 0);
        $display("cancel: ready=%0d done_seen=%0d q=%h r=%h", div_ready, done_seen, Quotient, Remainder);

        run_op(1'b0, 32'd9, 32'd3, lat);
        $display("op after cancel: 9/3 -> q=%h r=%h lat=%0d", Quotient, Remainder, lat);
        check("post_cancel_lat", lat, 32);
        check("post_cancel_q",   Quotient,  32'd3);
        check("post_cancel_r",   Remainder, 32'd0);

        // Reset in the 5th BUSY cycle
        @(negedge clk);
        A         = 32'd1000;
        B         = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_q",    Quotient,  32'd0);
        check("midreset_r",    Remainder, 32'd0);
        check("midreset_dz",   {31'd0, DivZero}, 32'd0);
        check("midreset_done", {31'd0, done},    32'd0);
        resetn = 1'b1;
        check("midreset_ready", {31'd0, div_ready}, 32'd1);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);
        $display("reset mid-op: ready=%0d done_seen=%0d q=%h r=%h", div_ready, done_seen, Quotient, Remainder);

        // div_valid held high through BUSY must not restart the operation
        @(negedge clk);
        A         = 32'd1000;
        B         = 32'd3;
        div_valid = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        div_valid = 1'b0;
        if (!done) lat = 999;
        $display("held valid: 1000/3 -> q=%h r=%h lat=%0d", Quotient, Remainder, lat);
        check("held_valid_lat", lat, 32);
        check("held_valid_q",   Quotient,  32'd333);
        check("held_valid_r",   Remainder, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
